probe_pattern_gen: RTL



---
 rtl/probe_gen_pkg.sv | 13 +
 rtl/probe_gen_channel.sv | 52 +++++
 rtl/probe_pattern_gen.sv | 70 +++++++
 3 files changed

// File: rtl/probe_gen_pkg.sv
// probe_gen_pkg: shared types and constants for the probe pattern generator
package probe_gen_pkg;

    typedef enum logic [1:0] {
        MODE_INC  = 2'd0,
        MODE_DEC  = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_HOLD = 2'd3
    } mode_t;

    localparam logic [7:0] DEFAULT_TAPS_8 = 8'hB8;

endpackage

// File: rtl/probe_gen_channel.sv
// probe_gen_channel: one probe channel register with INC/DEC/LFSR/HOLD update
// LFSR mode is compiled only when PROBE_GEN_LFSR_EN is defined; otherwise it holds.
module probe_gen_channel
    import probe_gen_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS_8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] val,
    output logic             carry,
    output logic             borrow
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [WIDTH-1:0] nxt;

    assign sum    = {1'b0, val} + {1'b0, step};
    assign carry  = sum[WIDTH];
    assign borrow = val < step;

`ifdef PROBE_GEN_LFSR_EN
    // an all-zero register would lock the Galois shifter, so reload the seed
    assign lfsr_nxt = (val == '0) ? seed : ((val >> 1) ^ (val[0] ? TAPS : '0));
`else
    logic unused_lfsr;
    assign lfsr_nxt    = val;
    assign unused_lfsr = ^{TAPS, seed};
`endif

    // next channel value for the sampled mode
    always_comb begin
        nxt = (mode == MODE_INC)  ? sum[WIDTH-1:0] :
              (mode == MODE_DEC)  ? val - step :
              (mode == MODE_LFSR) ? lfsr_nxt : val;
    end

    // channel register: cleared by reset/restart, updated only on fire
    always_ff @(posedge clk) begin
        if (rst)
            val <= '0;
        else if (fire)
            val <= nxt;
    end

endmodule

// File: rtl/probe_pattern_gen.sv
// probe_pattern_gen: multi-channel probe test-pattern source with prescaler, tick and wrap strobes
// Optional LFSR pattern enabled by defining PROBE_GEN_LFSR_EN.
module probe_pattern_gen
    import probe_gen_pkg::*;
#(
    parameter int               NUM_CH = 4,
    parameter int               WIDTH  = 8,
    parameter int               DIV_W  = 16,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(DEFAULT_TAPS_8)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic [DIV_W-1:0]          div,
    input  logic                      restart,
    output logic [NUM_CH*WIDTH-1:0]   probes,
    output logic                      tick,
    output logic                      wrap
);

    logic [DIV_W-1:0]  pre_q;
    logic              fire;
    logic              clr;
    mode_t             mode_s;
    logic [NUM_CH-1:0] carry;
    logic [NUM_CH-1:0] borrow;
    logic              unused_flags;

    assign mode_s       = mode_t'(mode);
    assign clr          = rst | restart;
    // >= rather than == so lowering div below the running count still fires
    assign fire         = en && (pre_q >= div);
    assign unused_flags = ^{carry[NUM_CH-1:0], borrow[NUM_CH-1:0]};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        probe_gen_channel #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_ch (
            .clk    (clk),
            .rst    (clr),
            .fire   (fire),
            .mode   (mode_s),
            .step   (WIDTH'(k + 1)),
            .seed   (WIDTH'(k + 1)),
            .val    (probes[k*WIDTH +: WIDTH]),
            .carry  (carry[k]),
            .borrow (borrow[k])
        );
    end

    // prescaler and strobes; restart clears like reset and suppresses a same-cycle fire
    always_ff @(posedge clk) begin
        if (clr) begin
            pre_q <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (fire) begin
            pre_q <= '0;
            tick  <= 1'b1;
            wrap  <= ((mode_s == MODE_INC) && carry[0]) || ((mode_s == MODE_DEC) && borrow[0]);
        end else begin
            pre_q <= en ? pre_q + 1'b1 : pre_q;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end
    end

endmodule
